// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin arbiter sharing one I/O command/response channel among num_src_p requesters.
// An in-order tag FIFO records each issued command's source so responses can be steered back.
module bp_io_cmd_arbiter #(
  parameter int unsigned num_src_p         = 2,
  parameter int unsigned header_width_p    = 64,
  parameter int unsigned data_width_p      = 512,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_src_p*header_width_p-1:0]    src_cmd_header_i,
  input  logic [num_src_p*data_width_p-1:0]      src_cmd_data_i,
  input  logic [num_src_p-1:0]                   src_cmd_v_i,
  output logic [num_src_p-1:0]                   src_cmd_yumi_o,
  output logic [header_width_p-1:0]              io_cmd_header_o,
  output logic [data_width_p-1:0]                io_cmd_data_o,
  output logic                                   io_cmd_v_o,
  input  logic                                   io_cmd_yumi_i,
  input  logic [header_width_p-1:0]              io_resp_header_i,
  input  logic [data_width_p-1:0]                io_resp_data_i,
  input  logic                                   io_resp_v_i,
  output logic                                   io_resp_ready_and_o,
  output logic [header_width_p-1:0]              src_resp_header_o,
  output logic [data_width_p-1:0]                src_resp_data_o,
  output logic [num_src_p-1:0]                   src_resp_v_o,
  input  logic [num_src_p-1:0]                   src_resp_ready_and_i,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                   error_o
);

  localparam int unsigned src_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int unsigned ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p+1);

  typedef enum logic {E_IDLE, E_LOCK} state_e;

  state_e               state_q, state_d;
  logic [src_w_lp-1:0]  rr_q, rr_d;
  logic [src_w_lp-1:0]  grant_q, grant_d;
  logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 error_q, error_d;
  logic [src_w_lp-1:0]  tag_mem_q [max_outstanding_p];

  logic [header_width_p-1:0] hdr_a [num_src_p];
  logic [data_width_p-1:0]   dat_a [num_src_p];
  logic [src_w_lp-1:0]       rr_grant, g, h;
  logic                      rr_found, cmd_v, tag_full, tag_v, push, pop;
  int unsigned               idx;

  for (genvar k = 0; k < num_src_p; k++) begin : g_unpack
    assign hdr_a[k] = src_cmd_header_i[k*header_width_p +: header_width_p];
    assign dat_a[k] = src_cmd_data_i[k*data_width_p +: data_width_p];
  end

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_outstanding_p-1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search upward from rr_q with wrap; lowest offset wins.
  always_comb begin
    rr_grant = rr_q;
    rr_found = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= num_src_p) idx = idx - num_src_p;
      if (!rr_found && src_cmd_v_i[src_w_lp'(idx)]) begin
        rr_found = 1'b1;
        rr_grant = src_w_lp'(idx);
      end
    end
  end

  assign tag_full = (cnt_q == cnt_w_lp'(max_outstanding_p));
  assign tag_v    = (cnt_q != '0);
  assign h        = tag_mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    g       = rr_grant;
    cmd_v   = 1'b0;
    unique case (state_q)
      E_IDLE: begin
        g     = rr_grant;
        cmd_v = reset_n_i & rr_found & ~tag_full;
        if (cmd_v && !io_cmd_yumi_i) begin
          state_d = E_LOCK;
          grant_d = rr_grant;
        end
      end
      E_LOCK: begin
        g     = grant_q;
        cmd_v = reset_n_i & src_cmd_v_i[grant_q] & ~tag_full;
        if (io_cmd_yumi_i) state_d = E_IDLE;
      end
      default: state_d = E_IDLE;
    endcase
  end

  assign push = cmd_v & io_cmd_yumi_i;
  assign pop  = io_resp_v_i & io_resp_ready_and_o;

  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    error_d  = error_q | (io_resp_v_i & ~tag_v);
    if (push) begin
      rr_d     = (g == src_w_lp'(num_src_p-1)) ? '0 : g + 1'b1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    src_cmd_yumi_o = '0;
    src_resp_v_o   = '0;
    if (push) src_cmd_yumi_o[g] = 1'b1;
    if (reset_n_i && io_resp_v_i && tag_v) src_resp_v_o[h] = 1'b1;
  end

  assign io_cmd_v_o          = cmd_v;
  assign io_cmd_header_o     = hdr_a[g];
  assign io_cmd_data_o       = dat_a[g];
  assign io_resp_ready_and_o = reset_n_i & tag_v & src_resp_ready_and_i[h];
  assign src_resp_header_o   = io_resp_header_i;
  assign src_resp_data_o     = io_resp_data_i;
  assign outstanding_o       = cnt_q;
  assign error_o             = error_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= E_IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the occupancy count covers them.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= g;
  end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Self-checking bench for bp_io_cmd_arbiter: directed vector table, hand sequences for
// lock/backpressure/error/reset, and random traffic against a queue-based reference model.
module tb_bp_io_cmd_arbiter;
  localparam int unsigned N = 2, HW = 64, DW = 512, MAX = 4, CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N*HW-1:0]   src_cmd_header;
  logic [N*DW-1:0]   src_cmd_data;
  logic [N-1:0]      src_v, src_yumi_o, src_resp_v_o, rdy;
  logic [HW-1:0]     cmd_hdr_o, resp_hdr, src_resp_hdr_o;
  logic [DW-1:0]     cmd_dat_o, resp_dat, src_resp_dat_o;
  logic              cmd_v_o, cmd_yumi, resp_v, resp_rdy_o, err_o;
  logic [CW-1:0]     outst_o;
  logic [HW-1:0]     hdr_a [N];
  logic [DW-1:0]     dat_a [N];

  always_comb begin
    src_cmd_header = '0;
    src_cmd_data   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      src_cmd_header[k*HW +: HW] = hdr_a[k];
      src_cmd_data[k*DW +: DW]   = dat_a[k];
    end
  end

  bp_io_cmd_arbiter #(
    .num_src_p(N), .header_width_p(HW), .data_width_p(DW), .max_outstanding_p(MAX)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .src_cmd_header_i(src_cmd_header), .src_cmd_data_i(src_cmd_data),
    .src_cmd_v_i(src_v), .src_cmd_yumi_o(src_yumi_o),
    .io_cmd_header_o(cmd_hdr_o), .io_cmd_data_o(cmd_dat_o),
    .io_cmd_v_o(cmd_v_o), .io_cmd_yumi_i(cmd_yumi),
    .io_resp_header_i(resp_hdr), .io_resp_data_i(resp_dat),
    .io_resp_v_i(resp_v), .io_resp_ready_and_o(resp_rdy_o),
    .src_resp_header_o(src_resp_hdr_o), .src_resp_data_o(src_resp_dat_o),
    .src_resp_v_o(src_resp_v_o), .src_resp_ready_and_i(rdy),
    .outstanding_o(outst_o), .error_o(err_o)
  );

  int checks = 0, errors = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: FIFO of source ids in issue order plus arbitration bookkeeping.
  int unsigned mq[$];
  int unsigned m_rr, m_lk, m_g;
  bit          m_lock, m_err, m_cmd_v, m_rdy;
  logic [N-1:0] m_yumi, m_rv;

  function automatic void model_reset();
    mq.delete(); m_rr = 0; m_lock = 0; m_lk = 0; m_err = 0;
  endfunction

  function automatic void predict();
    bit any = 0;
    m_g = 0;
    if (m_lock) begin
      m_g = m_lk; any = src_v[m_lk];
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned c = (m_rr + k) % N;
        if (!any && src_v[c]) begin m_g = c; any = 1; end
      end
    end
    m_cmd_v = any && (mq.size() < MAX);
    m_yumi = '0;
    if (m_cmd_v && cmd_yumi) m_yumi[m_g] = 1'b1;
    m_rv = '0; m_rdy = 0;
    if (mq.size() > 0) begin
      m_rdy = rdy[mq[0]];
      if (resp_v) m_rv[mq[0]] = 1'b1;
    end
  endfunction

  function automatic void commit();
    if (resp_v && mq.size() == 0) m_err = 1;
    if (resp_v && m_rdy) void'(mq.pop_front());
    if (m_cmd_v && cmd_yumi) begin
      mq.push_back(m_g); m_rr = (m_g + 1) % N; m_lock = 0;
    end else if (m_cmd_v && !m_lock) begin
      m_lock = 1; m_lk = m_g;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    predict();
    chk("cmd_v", cmd_v_o, m_cmd_v);
    chk("cmd_yumi", src_yumi_o, m_yumi);
    if (m_cmd_v) begin
      chk("cmd_hdr", cmd_hdr_o, hdr_a[m_g]);
      chk("cmd_data", cmd_dat_o == dat_a[m_g], 1);
    end
    chk("resp_v", src_resp_v_o, m_rv);
    chk("resp_rdy", resp_rdy_o, m_rdy);
    chk("outstanding", outst_o, mq.size());
    chk("error", err_o, m_err);
    chk("resp_hdr", src_resp_hdr_o, resp_hdr);
    chk("resp_data", src_resp_dat_o == resp_dat, 1);
    commit();
    @(posedge clk); #1;
  endtask

  task automatic set_in(logic [N-1:0] v, logic y, logic rv, logic [N-1:0] r);
    src_v = v; cmd_yumi = y; resp_v = rv; rdy = r;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_outstanding", outst_o, 0);
    chk("rst_error", err_o, 0);
    chk("rst_cmd_v", cmd_v_o, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] v; logic y; logic rv; logic [1:0] r;
    logic ecv; logic [1:0] eyumi; logic [1:0] erv; logic erdy; logic [2:0] eout;
  } vec_t;
  vec_t tbl[20];

  initial begin
    // Credit limit, alternation, drain order and issue-order response steering.
    tbl[0]  = '{2'b11,1,0,2'b00, 1,2'b01,2'b00,0,3'd0};
    tbl[1]  = '{2'b11,1,0,2'b00, 1,2'b10,2'b00,0,3'd1};
    tbl[2]  = '{2'b11,1,0,2'b00, 1,2'b01,2'b00,0,3'd2};
    tbl[3]  = '{2'b11,1,0,2'b00, 1,2'b10,2'b00,0,3'd3};
    tbl[4]  = '{2'b11,0,0,2'b00, 0,2'b00,2'b00,0,3'd4};
    tbl[5]  = '{2'b11,0,1,2'b11, 0,2'b00,2'b01,1,3'd4};
    tbl[6]  = '{2'b11,0,0,2'b00, 1,2'b00,2'b00,0,3'd3};
    tbl[7]  = '{2'b11,1,0,2'b00, 1,2'b01,2'b00,0,3'd3};
    tbl[8]  = '{2'b00,0,1,2'b11, 0,2'b00,2'b10,1,3'd4};
    tbl[9]  = '{2'b00,0,1,2'b11, 0,2'b00,2'b01,1,3'd3};
    tbl[10] = '{2'b00,0,1,2'b11, 0,2'b00,2'b10,1,3'd2};
    tbl[11] = '{2'b00,0,1,2'b11, 0,2'b00,2'b01,1,3'd1};
    tbl[12] = '{2'b00,0,0,2'b11, 0,2'b00,2'b00,0,3'd0};
    tbl[13] = '{2'b10,1,0,2'b00, 1,2'b10,2'b00,0,3'd0};
    tbl[14] = '{2'b01,1,0,2'b00, 1,2'b01,2'b00,0,3'd1};
    tbl[15] = '{2'b10,1,0,2'b00, 1,2'b10,2'b00,0,3'd2};
    tbl[16] = '{2'b00,0,1,2'b11, 0,2'b00,2'b10,1,3'd3};
    tbl[17] = '{2'b00,0,1,2'b11, 0,2'b00,2'b01,1,3'd2};
    tbl[18] = '{2'b00,0,1,2'b11, 0,2'b00,2'b10,1,3'd1};
    tbl[19] = '{2'b00,0,0,2'b00, 0,2'b00,2'b00,0,3'd0};

    hdr_a[0] = 64'hA0A0_0000_1111_0000; hdr_a[1] = 64'hB1B1_0000_2222_0001;
    dat_a[0] = {16{32'hDEAD_0000}};     dat_a[1] = {16{32'hBEEF_0001}};
    resp_hdr = 64'h1234_5678_9ABC_DEF0; resp_dat = {16{32'h0F0F_F0F0}};
    model_reset();

    // Reset with both sources requesting and a response offered: every output low.
    reset_n = 1'b0;
    set_in(2'b11, 1'b0, 1'b1, 2'b11);
    #2;
    chk("rst_cmd_v", cmd_v_o, 0);
    chk("rst_yumi", src_yumi_o, 0);
    chk("rst_resp_v", src_resp_v_o, 0);
    chk("rst_resp_rdy", resp_rdy_o, 0);
    chk("rst_outstanding", outst_o, 0);
    chk("rst_error", err_o, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].v, tbl[i].y, tbl[i].rv, tbl[i].r);
      #2;
      chk($sformatf("vec%0d_cmd_v", i), cmd_v_o, tbl[i].ecv);
      chk($sformatf("vec%0d_yumi", i), src_yumi_o, tbl[i].eyumi);
      chk($sformatf("vec%0d_resp_v", i), src_resp_v_o, tbl[i].erv);
      chk($sformatf("vec%0d_resp_rdy", i), resp_rdy_o, tbl[i].erdy);
      chk($sformatf("vec%0d_outstanding", i), outst_o, tbl[i].eout);
      tick();
    end

    // Lock: move rr to src1, then src0 waits unconsumed while src1 arrives.
    do_reset();
    set_in(2'b01, 1, 0, 2'b00); tick();
    set_in(2'b00, 0, 1, 2'b01); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(2'b01, 0, 0, 2'b00); #2;
      chk("lock_wait_hdr", cmd_hdr_o, hdr_a[0]);
      tick();
    end
    set_in(2'b11, 0, 0, 2'b00); #2;
    chk("lock_hold_hdr", cmd_hdr_o, hdr_a[0]);
    chk("lock_hold_v", cmd_v_o, 1);
    tick();
    set_in(2'b11, 1, 0, 2'b00); #2;
    chk("lock_pop_yumi", src_yumi_o, 2'b01);
    tick();
    set_in(2'b11, 0, 0, 2'b00); #2;
    chk("lock_next_hdr", cmd_hdr_o, hdr_a[1]);
    tick();
    set_in(2'b11, 1, 0, 2'b00); tick();
    set_in(2'b00, 0, 1, 2'b11); tick(); tick();
    set_in(2'b00, 0, 0, 2'b00); tick();

    // Response backpressure on head tag src0.
    set_in(2'b01, 1, 0, 2'b00); tick();
    for (int i = 0; i < 2; i++) begin
      set_in(2'b00, 0, 1, 2'b10); #2;
      chk("bp_rdy_low", resp_rdy_o, 0);
      chk("bp_resp_v", src_resp_v_o, 2'b01);
      chk("bp_outstanding", outst_o, 1);
      tick();
    end
    set_in(2'b00, 0, 1, 2'b01); #2;
    chk("bp_rdy_high", resp_rdy_o, 1);
    tick();
    set_in(2'b00, 0, 0, 2'b00); #2;
    chk("bp_drained", outst_o, 0);
    tick();

    // Stray response sets sticky error; reset mid-burst clears state at once.
    set_in(2'b00, 0, 1, 2'b11); #2;
    chk("stray_rdy", resp_rdy_o, 0);
    chk("stray_resp_v", src_resp_v_o, 0);
    chk("stray_err_before", err_o, 0);
    tick();
    set_in(2'b00, 0, 0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      #2; chk("err_sticky", err_o, 1);
      tick();
    end
    set_in(2'b11, 1, 0, 2'b00); tick(); tick();
    #2; chk("burst_outstanding", outst_o, 2);
    do_reset();
    set_in(2'b00, 0, 0, 2'b00); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        hdr_a[k] = {$urandom, $urandom};
        for (int unsigned w = 0; w < DW/32; w++) dat_a[k][w*32 +: 32] = $urandom;
      end
      resp_hdr = {$urandom, $urandom};
      for (int unsigned w = 0; w < DW/32; w++) resp_dat[w*32 +: 32] = $urandom;
      src_v  = N'($urandom);
      rdy    = N'($urandom);
      resp_v = (mq.size() > 0) ? 1'($urandom) : ($urandom_range(0, 31) == 0);
      cmd_yumi = 1'b0;
      predict();
      cmd_yumi = m_cmd_v & 1'($urandom);
      tick();
      if (i == 400) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
